// File: rtl/acc_mul.sv
// acc_mul: sums N upstream products per block and offers each block sum through a dav_/rfd handshake
module acc_mul #(
  parameter int N = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] m,
  input  logic        ok,
  input  logic        rfd,
  output logic [23:0] s,
  output logic        dav_,
  output logic        ovf
);
  typedef enum logic [1:0] {O_IDLE, O_WAIT, O_DAV} state_t;
  state_t      r_st, w_nxt;
  logic [23:0] r_acc, r_s, w_sum;
  logic [7:0]  r_cnt;
  logic        r_dav_n, r_ovf, w_done, w_load, w_ovf_set;
  assign w_done = ok && (r_cnt == 8'(N - 1));
  assign w_sum  = r_acc + 24'(m);
  assign s      = r_s;
  assign dav_   = r_dav_n;
  assign ovf    = r_ovf;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (ok) begin
      r_acc <= w_done ? '0 : w_sum;
      r_cnt <= w_done ? '0 : r_cnt + 8'd1;
    end
  end
  // A sum finishing while the previous result is still unclaimed is dropped and flagged
  always_comb begin
    w_nxt     = r_st;
    w_load    = 1'b0;
    w_ovf_set = 1'b0;
    case (r_st)
      O_IDLE: begin
        w_load = w_done;
        w_nxt  = w_done ? O_WAIT : O_IDLE;
      end
      O_WAIT: begin
        w_ovf_set = w_done;
        w_nxt     = rfd ? O_DAV : O_WAIT;
      end
      O_DAV: begin
        w_load    = w_done && !rfd;
        w_ovf_set = w_done && rfd;
        w_nxt     = rfd ? O_DAV : (w_done ? O_WAIT : O_IDLE);
      end
      default: w_nxt = O_IDLE;
    endcase
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_st    <= O_IDLE;
      r_s     <= '0;
      r_dav_n <= 1'b1;
      r_ovf   <= 1'b0;
    end else begin
      r_st    <= w_nxt;
      r_dav_n <= (w_nxt != O_DAV);
      r_ovf   <= r_ovf | w_ovf_set;
      if (w_load) r_s <= w_sum;
    end
  end
endmodule
